// File: rtl/sys_arr_pkg.sv
// Shared types and helpers for the sys_arr_nxn systolic matrix multiplier.
package sys_arr_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    // Rising edges from the accepting edge to valid: LOAD, a feed-priming cycle, 3N-2 steps, result register.
    function automatic int sys_arr_latency(input int n);
        return 3 * n + 1;
    endfunction

endpackage

// File: rtl/sys_arr_pe.sv
// Systolic processing element: registered A/B pass-through plus an unsigned multiply-accumulate.
module sys_arr_pe #(
    parameter int DW = 8,
    parameter int AW = 17
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic [DW-1:0] a_in,
    input  logic [DW-1:0] b_in,
    output logic [DW-1:0] a_out,
    output logic [DW-1:0] b_out,
    output logic [AW-1:0] acc
);

    logic [2*DW-1:0] prod;

    assign prod = a_in * b_in;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            a_out <= '0;
            b_out <= '0;
            acc   <= '0;
        end else begin
            a_out <= a_in;
            b_out <= b_in;
            acc   <= acc + AW'(prod);
        end
    end

endmodule

// File: rtl/sys_arr_nxn.sv
// N x N output-stationary systolic multiplier, C = A x B, unsigned.
// Define SYS_ARR_SATURATE_EN to clamp results to 2^CW-1 instead of wrapping.
module sys_arr_nxn
    import sys_arr_pkg::*;
#(
    parameter int N  = 3,
    parameter int DW = 8,
    parameter int CW = 2*DW + $clog2(N) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [N*N*DW-1:0] a_flat,
    input  logic [N*N*DW-1:0] b_flat,
    output logic              busy,
    output logic              valid,
    output logic [N*N*CW-1:0] c_flat
);

    localparam int AW   = 2*DW + $clog2(N) + 1;
    localparam int LAT  = sys_arr_latency(N);
    localparam int CNTW = $clog2(LAT);
    localparam logic [CNTW-1:0] LAST = CNTW'(LAT - 2);

    state_t                    state_q, state_d;
    logic                      accept;
    logic                      clr;
    logic [CNTW-1:0]           cnt;
    logic [N*N*DW-1:0]         a_q, b_q;
    logic [N-1:0][DW-1:0]      a_feed, b_feed;
    logic [N-1:0][N-1:0][DW-1:0] a_h, b_v;
    logic [N*N-1:0][AW-1:0]    acc;
    logic [N*N*CW-1:0]         c_nxt;

    function automatic logic [CW-1:0] reduce(input logic [AW-1:0] v);
`ifdef SYS_ARR_SATURATE_EN
        localparam int XW = (AW > CW) ? AW : CW;
        if (XW'(v) > XW'({CW{1'b1}}))
            return {CW{1'b1}};
`endif
        return CW'(v);
    endfunction

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE, DONE: if (start) begin
                accept  = 1'b1;
                state_d = LOAD;
            end
            LOAD:    state_d = RUN;
            RUN:     if (cnt == LAST) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == LOAD) || (state_q == RUN);
    assign clr  = (state_q == LOAD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            valid   <= 1'b0;
            c_flat  <= '0;
        end else begin
            state_q <= state_d;
            cnt     <= (state_q == RUN) ? cnt + 1'b1 : '0;
            if (accept) begin
                a_q   <= a_flat;
                b_q   <= b_flat;
                valid <= 1'b0;
            end
            if (state_q == RUN && cnt == LAST) begin
                c_flat <= c_nxt;
                valid  <= 1'b1;
            end
        end
    end

    // Edge feeders: row i of A and column i of B enter skewed by i cycles.
    for (genvar i = 0; i < N; i++) begin : g_feed
        logic [DW-1:0] a_nxt, b_nxt;

        always_comb begin
            int k;
            k     = int'(cnt) - i;
            a_nxt = '0;
            b_nxt = '0;
            if (state_q == RUN) begin
                for (int j = 0; j < N; j++) begin
                    if (k == j) begin
                        a_nxt = a_q[(i*N + j)*DW +: DW];
                        b_nxt = b_q[(j*N + i)*DW +: DW];
                    end
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst || clr) begin
                a_feed[i] <= '0;
                b_feed[i] <= '0;
            end else begin
                a_feed[i] <= a_nxt;
                b_feed[i] <= b_nxt;
            end
        end
    end

    for (genvar r = 0; r < N; r++) begin : g_row
        for (genvar c = 0; c < N; c++) begin : g_col
            logic [DW-1:0] a_in, b_in;

            if (c == 0) begin : g_aw
                assign a_in = a_feed[r];
            end else begin : g_ai
                assign a_in = a_h[r][c-1];
            end
            if (r == 0) begin : g_bn
                assign b_in = b_feed[c];
            end else begin : g_bi
                assign b_in = b_v[r-1][c];
            end

            sys_arr_pe #(.DW(DW), .AW(AW)) u_pe (
                .clk   (clk),
                .rst   (rst),
                .clr   (clr),
                .a_in  (a_in),
                .b_in  (b_in),
                .a_out (a_h[r][c]),
                .b_out (b_v[r][c]),
                .acc   (acc[r*N + c])
            );

            assign c_nxt[(r*N + c)*CW +: CW] = reduce(acc[r*N + c]);
        end
    end

endmodule

// File: tb/tb_sys_arr_nxn.sv
// Scoreboard bench for sys_arr_nxn: four configurations (N=3, N=3/CW=8, N=1, N=4) run side by side.
module tb_sys_arr_nxn;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 4; g++) begin : g_cfg
        localparam int NN  = (g == 2) ? 1 : ((g == 3) ? 4 : 3);
        localparam int CWD = (g == 1) ? 8 : (16 + $clog2(NN) + 1);
        localparam int AWD = NN*NN*8;
        localparam int CWT = NN*NN*CWD;

        logic           rst, start, busy, valid;
        logic [AWD-1:0] a_flat, b_flat;
        logic [CWT-1:0] c_flat;
        logic [CWT-1:0] q_c[$];
        int             q_t[$];
        logic [CWT-1:0] last = '0;
        bit             vprev = 1'b0;
        bit             fin = 1'b0;

        sys_arr_nxn #(.N(NN), .DW(8), .CW(CWD)) u_dut (
            .clk    (clk),
            .rst    (rst),
            .start  (start),
            .a_flat (a_flat),
            .b_flat (b_flat),
            .busy   (busy),
            .valid  (valid),
            .c_flat (c_flat)
        );

        // kind 0: A=identity, B=1..N*N; 1: all 255; 2: all 10; 3: A=3, B=4; else random
        function automatic logic [AWD-1:0] gen(input int kind, input bit is_a);
            logic [AWD-1:0] v;
            logic [7:0]     e;
            v = '0;
            for (int r = 0; r < NN; r++)
                for (int c = 0; c < NN; c++) begin
                    case (kind)
                        0:       e = is_a ? 8'(r == c) : 8'(r*NN + c + 1);
                        1:       e = 8'd255;
                        2:       e = 8'd10;
                        3:       e = is_a ? 8'd3 : 8'd4;
                        default: e = 8'($urandom_range(0, 255));
                    endcase
                    v[(r*NN + c)*8 +: 8] = e;
                end
            return v;
        endfunction

        function automatic logic [CWT-1:0] model(input logic [AWD-1:0] a, input logic [AWD-1:0] b);
            logic [CWT-1:0] res;
            longint         s, mx;
            res = '0;
            mx  = (longint'(1) << CWD) - 1;
            for (int r = 0; r < NN; r++)
                for (int c = 0; c < NN; c++) begin
                    s = 0;
                    for (int k = 0; k < NN; k++)
                        s += longint'(a[(r*NN + k)*8 +: 8]) * longint'(b[(k*NN + c)*8 +: 8]);
`ifdef SYS_ARR_SATURATE_EN
                    if (s > mx) s = mx;
`endif
                    res[(r*NN + c)*CWD +: CWD] = CWD'(s & mx);
                end
            return res;
        endfunction

        task automatic cmp_c(input string tag, input logic [CWT-1:0] exp);
            for (int i = 0; i < NN*NN; i++)
                chk($sformatf("g%0d %s c[%0d]", g, tag, i),
                    64'(c_flat[i*CWD +: CWD]), 64'(exp[i*CWD +: CWD]));
        endtask

        always @(negedge clk) begin
            if (valid && !vprev) begin
                if (q_c.size() == 0) begin
                    chk($sformatf("g%0d unexpected valid", g), 64'(valid), 64'(0));
                end else begin
                    logic [CWT-1:0] e;
                    int             t;
                    e = q_c.pop_front();
                    t = q_t.pop_front();
                    cmp_c("result", e);
                    chk($sformatf("g%0d latency", g), 64'(cyc - t), 64'(3*NN + 1));
                    last = e;
                end
            end
            vprev = valid;
        end

        task automatic go(input logic [AWD-1:0] a, input logic [AWD-1:0] b);
            a_flat = a;
            b_flat = b;
            start  = 1'b1;
            q_c.push_back(model(a, b));
            q_t.push_back(cyc + 1);
        endtask

        task automatic drain();
            for (int i = 0; i < 200 && q_c.size() != 0; i++) @(negedge clk);
            chk($sformatf("g%0d pending results", g), 64'(q_c.size()), 64'(0));
            q_c.delete();
            q_t.delete();
        endtask

        // One multiply; optionally pokes start and new operands mid-run.
        task automatic run1(input int kind, input bit mid);
            go(gen(kind, 1'b1), gen(kind, 1'b0));
            for (int k = 0; k <= 3*NN + 1; k++) begin
                @(negedge clk);
                if (k == 0) start = 1'b0;
                if (mid && k == 2) begin
                    start  = 1'b1;
                    a_flat = gen(5, 1'b1);
                    b_flat = gen(5, 1'b0);
                end
                if (mid && k == 3) start = 1'b0;
                if (k == 3*NN) cmp_c("held", last);
                chk($sformatf("g%0d busy k=%0d", g, k), 64'(busy), 64'(k <= 3*NN));
            end
            repeat (2) @(negedge clk);
            chk($sformatf("g%0d valid in DONE", g), 64'(valid), 64'(1));
            cmp_c("done hold", last);
            drain();
        endtask

        task automatic rst_mid();
            go(gen(5, 1'b1), gen(5, 1'b0));
            @(negedge clk);
            start = 1'b0;
            repeat (4) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            q_c.delete();
            q_t.delete();
            last = '0;
            chk($sformatf("g%0d busy after rst", g), 64'(busy), 64'(0));
            chk($sformatf("g%0d valid after rst", g), 64'(valid), 64'(0));
            cmp_c("after rst", '0);
        endtask

        // Start held high: DONE restarts straight away, operands refreshed after each accept.
        task automatic b2b(input int n);
            int t;
            go(gen(5, 1'b1), gen(5, 1'b0));
            t = cyc + 1;
            @(negedge clk);
            for (int i = 1; i < n; i++) begin
                a_flat = gen(5, 1'b1);
                b_flat = gen(5, 1'b0);
                t += 3*NN + 2;
                q_c.push_back(model(a_flat, b_flat));
                q_t.push_back(t);
                repeat (3*NN + 2) @(negedge clk);
            end
            start = 1'b0;
            drain();
        endtask

        initial begin
            rst    = 1'b1;
            start  = 1'b1;
            a_flat = gen(5, 1'b1);
            b_flat = gen(5, 1'b0);
            repeat (2) @(negedge clk);
            chk($sformatf("g%0d reset busy", g), 64'(busy), 64'(0));
            chk($sformatf("g%0d reset valid", g), 64'(valid), 64'(0));
            cmp_c("reset", '0);
            rst   = 1'b0;
            start = 1'b0;
            @(negedge clk);
            run1(0, 1'b0);
            run1(1, 1'b0);
            run1(2, 1'b0);
            run1(3, 1'b0);
            run1(5, 1'b0);
            run1(5, 1'b0);
            rst_mid();
            run1(5, 1'b0);
            run1(5, 1'b1);
            b2b(3);
            run1(0, 1'b0);
            fin = 1'b1;
        end
    end

    initial begin
        for (int t = 0; t < 20000 && !(g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin && g_cfg[3].fin); t++)
            @(posedge clk);
        chk("all configs finished",
            64'(g_cfg[0].fin & g_cfg[1].fin & g_cfg[2].fin & g_cfg[3].fin), 64'(1));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
